// File: rtl/ex_mem_register.sv
// EX->MEM pipeline register.
// Captures the ALU result/zero flag and the EX control bundle, resolves
// branch-if-zero into a one-cycle taken pulse, drives MEM->EX forwarding
// selects and the load-use hazard flag, and counts valid instructions.
module ex_mem_register #(
  parameter int N  = 32,
  parameter int RW = 5
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          STALL,
  input  logic          FLUSH,
  input  logic          EX_VALID,
  input  logic [N-1:0]  EX_RESULT,
  input  logic          EX_Z,
  input  logic [N-1:0]  EX_STORE_DATA,
  input  logic [RW-1:0] EX_RD,
  input  logic          EX_REG_WE,
  input  logic          EX_MEM_RE,
  input  logic          EX_MEM_WE,
  input  logic          EX_BRANCH,
  input  logic [N-1:0]  EX_BR_TARGET,
  input  logic [RW-1:0] FWD_RS1,
  input  logic [RW-1:0] FWD_RS2,
  output logic          MEM_VALID,
  output logic [N-1:0]  MEM_RESULT,
  output logic          MEM_Z,
  output logic [N-1:0]  MEM_STORE_DATA,
  output logic [RW-1:0] MEM_RD,
  output logic          MEM_REG_WE,
  output logic          MEM_MEM_RE,
  output logic          MEM_MEM_WE,
  output logic          BR_TAKEN,
  output logic [N-1:0]  BR_TARGET,
  output logic          FWD_SEL_A,
  output logic          FWD_SEL_B,
  output logic          LOAD_USE,
  output logic [31:0]   RETIRED_COUNT
);

  // Stored MEM-stage bundle; a flushed bubble is the all-zero value.
  typedef struct packed {
    logic          valid;
    logic [N-1:0]  result;
    logic          z;
    logic [N-1:0]  store_data;
    logic [RW-1:0] rd;
    logic          reg_we;
    logic          mem_re;
    logic          mem_we;
  } stage_t;

  stage_t        stage;
  stage_t        stage_next;
  logic          capture;
  logic          br_taken;
  logic [N-1:0]  br_target;
  logic [31:0]   retired_count;
  logic          rd_nz;
  logic          hit_rs1;
  logic          hit_rs2;

  // A normal load happens only when neither flush nor stall is asserted.
  assign capture = ~FLUSH & ~STALL;

  // Build the captured bundle: control bits are squashed for an invalid
  // slot (data still flows), and writes to r0 are dropped here so every
  // downstream consumer sees a clean REG_WE.
  always_comb begin
    stage_next            = '0;
    stage_next.valid      = EX_VALID;
    stage_next.result     = EX_RESULT;
    stage_next.z          = EX_Z;
    stage_next.store_data = EX_STORE_DATA;
    stage_next.rd         = EX_RD;
    stage_next.reg_we     = EX_VALID & EX_REG_WE & (EX_RD != '0);
    stage_next.mem_re     = EX_VALID & EX_MEM_RE;
    stage_next.mem_we     = EX_VALID & EX_MEM_WE;
  end

  // MEM-stage bundle: flush wins over stall, stall holds, otherwise capture.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)          stage <= '0;
    else if (FLUSH)   stage <= '0;
    else if (!STALL)  stage <= stage_next;
  end

  // Branch resolution: taken pulse lasts exactly one capture edge; the
  // target register holds so it stays stable between branches.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      br_taken  <= 1'b0;
      br_target <= '0;
    end else begin
      br_taken <= capture & EX_VALID & EX_BRANCH & EX_Z;
      if (capture) br_target <= EX_BR_TARGET;
    end
  end

  // Retired counter: one per valid captured instruction, wraps naturally.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                      retired_count <= '0;
    else if (capture && EX_VALID) retired_count <= retired_count + 32'd1;
  end

  // Hazard detection from registered state. Loads never forward (data is
  // not ready yet), so FWD_SEL and LOAD_USE are mutually exclusive.
  always_comb begin
    rd_nz     = stage.valid & stage.reg_we & (stage.rd != '0);
    hit_rs1   = rd_nz & (stage.rd == FWD_RS1);
    hit_rs2   = rd_nz & (stage.rd == FWD_RS2);
    FWD_SEL_A = hit_rs1 & ~stage.mem_re;
    FWD_SEL_B = hit_rs2 & ~stage.mem_re;
    LOAD_USE  = stage.mem_re & (hit_rs1 | hit_rs2);
  end

  assign MEM_VALID      = stage.valid;
  assign MEM_RESULT     = stage.result;
  assign MEM_Z          = stage.z;
  assign MEM_STORE_DATA = stage.store_data;
  assign MEM_RD         = stage.rd;
  assign MEM_REG_WE     = stage.reg_we;
  assign MEM_MEM_RE     = stage.mem_re;
  assign MEM_MEM_WE     = stage.mem_we;
  assign BR_TAKEN       = br_taken;
  assign BR_TARGET      = br_target;
  assign RETIRED_COUNT  = retired_count;

endmodule

// File: tb/tb_ex_mem_register.sv
// Directed bench for ex_mem_register: a table of per-edge vectors with
// hand-computed results, plus sequences for async reset and counter wrap.
module tb_ex_mem_register;

  localparam int N  = 32;
  localparam int RW = 5;

  logic          CLK = 1'b0;
  logic          RST;
  logic          STALL, FLUSH, EX_VALID, EX_Z, EX_REG_WE, EX_MEM_RE, EX_MEM_WE, EX_BRANCH;
  logic [N-1:0]  EX_RESULT, EX_STORE_DATA, EX_BR_TARGET;
  logic [RW-1:0] EX_RD, FWD_RS1, FWD_RS2;
  logic          MEM_VALID, MEM_Z, MEM_REG_WE, MEM_MEM_RE, MEM_MEM_WE;
  logic [N-1:0]  MEM_RESULT, MEM_STORE_DATA, BR_TARGET;
  logic [RW-1:0] MEM_RD;
  logic          BR_TAKEN, FWD_SEL_A, FWD_SEL_B, LOAD_USE;
  logic [31:0]   RETIRED_COUNT;

  int checks   = 0;
  int failures = 0;

  ex_mem_register #(.N(N), .RW(RW)) dut (
    .CLK(CLK), .RST(RST), .STALL(STALL), .FLUSH(FLUSH),
    .EX_VALID(EX_VALID), .EX_RESULT(EX_RESULT), .EX_Z(EX_Z),
    .EX_STORE_DATA(EX_STORE_DATA), .EX_RD(EX_RD), .EX_REG_WE(EX_REG_WE),
    .EX_MEM_RE(EX_MEM_RE), .EX_MEM_WE(EX_MEM_WE), .EX_BRANCH(EX_BRANCH),
    .EX_BR_TARGET(EX_BR_TARGET), .FWD_RS1(FWD_RS1), .FWD_RS2(FWD_RS2),
    .MEM_VALID(MEM_VALID), .MEM_RESULT(MEM_RESULT), .MEM_Z(MEM_Z),
    .MEM_STORE_DATA(MEM_STORE_DATA), .MEM_RD(MEM_RD), .MEM_REG_WE(MEM_REG_WE),
    .MEM_MEM_RE(MEM_MEM_RE), .MEM_MEM_WE(MEM_MEM_WE), .BR_TAKEN(BR_TAKEN),
    .BR_TARGET(BR_TARGET), .FWD_SEL_A(FWD_SEL_A), .FWD_SEL_B(FWD_SEL_B),
    .LOAD_USE(LOAD_USE), .RETIRED_COUNT(RETIRED_COUNT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    // inputs
    logic stall, flush, valid, z, reg_we, mem_re, mem_we, branch;
    logic [31:0] result, sdata, target;
    logic [4:0]  rd, rs1, rs2;
    // expected after the edge
    logic e_valid, e_z, e_reg_we, e_mem_re, e_mem_we, e_br;
    logic [31:0] e_result, e_sdata, e_target, e_count;
    logic [4:0]  e_rd;
    logic e_fa, e_fb, e_lu;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    STALL = v.stall; FLUSH = v.flush; EX_VALID = v.valid; EX_Z = v.z;
    EX_REG_WE = v.reg_we; EX_MEM_RE = v.mem_re; EX_MEM_WE = v.mem_we;
    EX_BRANCH = v.branch; EX_RESULT = v.result; EX_STORE_DATA = v.sdata;
    EX_BR_TARGET = v.target; EX_RD = v.rd; FWD_RS1 = v.rs1; FWD_RS2 = v.rs2;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " valid"},  {31'd0, MEM_VALID}, 0);
    chk({tag, " result"}, MEM_RESULT, 0);
    chk({tag, " z"},      {31'd0, MEM_Z}, 0);
    chk({tag, " sdata"},  MEM_STORE_DATA, 0);
    chk({tag, " rd"},     {27'd0, MEM_RD}, 0);
    chk({tag, " ctrl"},   {29'd0, MEM_REG_WE, MEM_MEM_RE, MEM_MEM_WE}, 0);
    chk({tag, " br"},     {31'd0, BR_TAKEN}, 0);
    chk({tag, " target"}, BR_TARGET, 0);
    chk({tag, " hazard"}, {29'd0, FWD_SEL_A, FWD_SEL_B, LOAD_USE}, 0);
    chk({tag, " count"},  RETIRED_COUNT, 0);
  endtask

  function automatic vec_t mk(
    input logic stall, flush, valid, z, reg_we, mem_re, mem_we, branch,
    input logic [31:0] result, sdata, target, input logic [4:0] rd, rs1, rs2,
    input logic e_valid, e_z, e_reg_we, e_mem_re, e_mem_we, e_br,
    input logic [31:0] e_result, e_sdata, e_target, e_count, input logic [4:0] e_rd,
    input logic e_fa, e_fb, e_lu);
    vec_t v;
    v.stall = stall; v.flush = flush; v.valid = valid; v.z = z; v.reg_we = reg_we;
    v.mem_re = mem_re; v.mem_we = mem_we; v.branch = branch; v.result = result;
    v.sdata = sdata; v.target = target; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
    v.e_valid = e_valid; v.e_z = e_z; v.e_reg_we = e_reg_we; v.e_mem_re = e_mem_re;
    v.e_mem_we = e_mem_we; v.e_br = e_br; v.e_result = e_result; v.e_sdata = e_sdata;
    v.e_target = e_target; v.e_count = e_count; v.e_rd = e_rd;
    v.e_fa = e_fa; v.e_fb = e_fb; v.e_lu = e_lu;
    return v;
  endfunction

  initial begin
    vec_t idle;
    //            st fl va z  we re wr br result  sdata  target rd rs1 rs2 | v  z  we re wr br result  sdata  target count rd fa fb lu
    vecs[0]  = mk(0, 0, 1, 0, 1, 0, 0, 0, 'h1234, 'h11,  'h0,   5, 5,  3,    1, 0, 1, 0, 0, 0, 'h1234, 'h11,  'h0,   1,    5, 1, 0, 0); // plain write, fwd A
    vecs[1]  = mk(0, 0, 1, 0, 1, 0, 0, 0, 'h55,   'h0,   'h0,   0, 0,  0,    1, 0, 0, 0, 0, 0, 'h55,   'h0,   'h0,   2,    0, 0, 0, 0); // r0 write dropped
    vecs[2]  = mk(0, 0, 1, 0, 1, 1, 0, 0, 'h100,  'h0,   'h0,   7, 1,  7,    1, 0, 1, 1, 0, 0, 'h100,  'h0,   'h0,   3,    7, 0, 0, 1); // load, use on rs2
    vecs[3]  = mk(1, 0, 1, 1, 1, 0, 0, 1, 'h999,  'h22,  'h44,  9, 7,  0,    1, 0, 1, 1, 0, 0, 'h100,  'h0,   'h0,   3,    7, 0, 0, 1); // stall holds
    vecs[4]  = mk(0, 0, 0, 1, 1, 0, 1, 0, 'hAA,   'h33,  'h8,   3, 3,  3,    0, 1, 0, 0, 0, 0, 'hAA,   'h33,  'h8,   3,    3, 0, 0, 0); // invalid: data only
    vecs[5]  = mk(0, 0, 1, 1, 1, 0, 0, 1, 'h0,    'h0,   'h40,  2, 2,  2,    1, 1, 1, 0, 0, 1, 'h0,    'h0,   'h40,  4,    2, 1, 1, 0); // taken branch
    vecs[6]  = mk(0, 0, 1, 0, 0, 0, 0, 0, 'h66,   'h0,   'h0,   6, 6,  0,    1, 0, 0, 0, 0, 0, 'h66,   'h0,   'h0,   5,    6, 0, 0, 0); // pulse ends
    vecs[7]  = mk(0, 0, 1, 0, 1, 0, 0, 1, 'h77,   'h0,   'h50,  8, 0,  8,    1, 0, 1, 0, 0, 0, 'h77,   'h0,   'h50,  6,    8, 0, 1, 0); // not-taken (Z=0)
    vecs[8]  = mk(1, 0, 1, 1, 1, 0, 0, 1, 'h88,   'h0,   'h80,  9, 8,  1,    1, 0, 1, 0, 0, 0, 'h77,   'h0,   'h50,  6,    8, 1, 0, 0); // stall blocks branch
    vecs[9]  = mk(1, 1, 1, 1, 1, 1, 0, 1, 'h99,   'h5,   'h90,  4, 0,  0,    0, 0, 0, 0, 0, 0, 'h0,    'h0,   'h50,  6,    0, 0, 0, 0); // stall+flush: bubble
    vecs[10] = mk(0, 0, 1, 0, 1, 1, 1, 0, 'hA0,   'hB0,  'hC0,  4, 4,  5,    1, 0, 1, 1, 1, 0, 'hA0,   'hB0,  'hC0,  7,    4, 0, 0, 1); // load+store kept

    idle = vecs[6];
    idle.valid = 0; idle.branch = 0; idle.reg_we = 0;
    drive(idle);

    // Power-on reset
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1 check_all_zero("reset");
    @(negedge CLK) RST = 1'b0;

    // Table-driven sequence; state carries from one vector to the next
    for (int i = 0; i < 11; i++) begin
      string t;
      t = $sformatf("v%0d", i);
      drive(vecs[i]);
      @(posedge CLK); #1;
      chk({t, " valid"},  {31'd0, MEM_VALID}, {31'd0, vecs[i].e_valid});
      chk({t, " result"}, MEM_RESULT, vecs[i].e_result);
      chk({t, " z"},      {31'd0, MEM_Z}, {31'd0, vecs[i].e_z});
      chk({t, " sdata"},  MEM_STORE_DATA, vecs[i].e_sdata);
      chk({t, " rd"},     {27'd0, MEM_RD}, {27'd0, vecs[i].e_rd});
      chk({t, " ctrl"},   {29'd0, MEM_REG_WE, MEM_MEM_RE, MEM_MEM_WE},
                          {29'd0, vecs[i].e_reg_we, vecs[i].e_mem_re, vecs[i].e_mem_we});
      chk({t, " br"},     {31'd0, BR_TAKEN}, {31'd0, vecs[i].e_br});
      chk({t, " target"}, BR_TARGET, vecs[i].e_target);
      chk({t, " count"},  RETIRED_COUNT, vecs[i].e_count);
      chk({t, " hazard"}, {29'd0, FWD_SEL_A, FWD_SEL_B, LOAD_USE},
                          {29'd0, vecs[i].e_fa, vecs[i].e_fb, vecs[i].e_lu});
      @(negedge CLK);
    end

    // Async reset mid-branch, with no clock edge in between
    drive(vecs[5]);
    @(posedge CLK); #1;
    chk("pre-rst br", {31'd0, BR_TAKEN}, 1);
    chk("pre-rst count", RETIRED_COUNT, 8);
    RST = 1'b1;
    #1 check_all_zero("async rst");
    @(negedge CLK);
    drive(idle);
    RST = 1'b0;

    // Counter wrap from all-ones
    force dut.retired_count = 32'hFFFF_FFFF;
    #1 release dut.retired_count;
    #1 chk("preload count", RETIRED_COUNT, 32'hFFFF_FFFF);
    drive(vecs[0]);
    @(posedge CLK); #1;
    chk("wrap count", RETIRED_COUNT, 0);
    chk("wrap result", MEM_RESULT, 'h1234);

    @(negedge CLK);
    drive(idle);
    @(posedge CLK); #1;
    chk("idle count", RETIRED_COUNT, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
